irq_dispatch_sequencer: RTL

- Sits between the interrupt latch/mask stage and the 6502 IRQ pin.
- Picks the highest-priority pending source (lowest index wins) and drives int_out.
- Hands the vector ID to the CPU through a 4-register bus window and tracks one in-service interrupt until software writes EOI.
- Generates the EOI strobe/ID back to the latch stage, with a watchdog that recovers from a missing EOI.

---
 rtl/irq_dispatch_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/irq_dispatch_sequencer.sv
// ============================================================================
// irq_dispatch_sequencer
// ----------------------------------------------------------------------------
// Sits between the interrupt latch/mask stage and the 6502 IRQ pin. Picks the
// lowest-index pending source, raises int_out, hands the vector to the CPU
// through a 4-register window, tracks one in-service interrupt until software
// writes EOI, and sends the EOI strobe/ID back to the latch stage. A watchdog
// forces EOI if software never writes it.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   i_data[7:0]  CPU write data
//   o_data[7:0]  CPU read data (combinational from registers)
//   addr[1:0]    register select: 0 vector, 1 EOI, 2 status, 3 control
//   cs           chip select
//   rwb          1 = read, 0 = write
//   int_pending  level pending vector from latch/mask stage
//   int_out      registered IRQ request to CPU, active-high
//   o_eoi        one-cycle EOI strobe to latch stage
//   o_eoi_id     source ID being cleared, valid while o_eoi = 1
// ============================================================================
module irq_dispatch_sequencer #(
    parameter int NUM_IRQ = 256,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    input  logic [1:0]         addr,
    input  logic               cs,
    input  logic               rwb,
    input  logic [NUM_IRQ-1:0] int_pending,
    output logic               int_out,
    output logic               o_eoi,
    output logic [IDX_W-1:0]   o_eoi_id
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_SERVICE} state_t;

    // Counter only needs to reach TIMEOUT-1.
    localparam int                CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit                WD_EN   = (TIMEOUT != 0);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_win, r_svc, w_arb_idx;
    logic             r_valid, w_arb_any;
    logic             r_en, r_spur, r_mism, r_tmo;
    logic [CNT_W-1:0] r_cnt;

    logic w_vec_rd, w_eoi_wr, w_stat_wr, w_ctrl_wr, w_eoi_match;
    logic w_ack, w_eoi_ok, w_eoi_bad, w_spur, w_wdog;
    logic [7:0] w_vec_data;

    // Lowest index wins: scan downward so the last hit is the lowest set bit.
    always_comb begin
        w_arb_idx = '0;
        w_arb_any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (int_pending[i]) begin
                w_arb_idx = IDX_W'(i);
                w_arb_any = 1'b1;
            end
        end
    end

    assign w_vec_rd    = cs &  rwb & (addr == 2'd0);
    assign w_eoi_wr    = cs & ~rwb & (addr == 2'd1);
    assign w_stat_wr   = cs & ~rwb & (addr == 2'd2);
    assign w_ctrl_wr   = cs & ~rwb & (addr == 2'd3);
    assign w_eoi_match = (i_data == 8'(r_svc));

    assign w_vec_data = (r_state == S_SERVICE) ? 8'(r_svc) :
                        (r_valid ? 8'(r_win) : 8'hFF);

    always_comb begin
        o_data = 8'h00;
        case (addr)
            2'd0:    o_data = w_vec_data;
            2'd2:    o_data = {r_en, 2'b00, r_tmo, r_mism, r_spur,
                               (r_state == S_SERVICE), int_out};
            2'd3:    o_data = {7'b0, r_en};
            default: o_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ack     = 1'b0;
        w_eoi_ok  = 1'b0;
        w_eoi_bad = 1'b0;
        w_spur    = 1'b0;
        w_wdog    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_spur    = w_vec_rd;
                w_eoi_bad = w_eoi_wr;
                if (r_valid && r_en) w_next = S_PEND;
            end
            S_PEND: begin
                w_eoi_bad = w_eoi_wr;
                // Acknowledge is taken before looking at a dropped source.
                if (w_vec_rd && r_valid) begin
                    w_ack  = 1'b1;
                    w_next = S_SERVICE;
                end else begin
                    w_spur = w_vec_rd;
                    if (!r_valid || !r_en) w_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (w_eoi_wr && w_eoi_match) begin
                    w_eoi_ok = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_eoi_wr) begin
                    w_eoi_bad = 1'b1;
                end
                if (WD_EN && (r_cnt == WD_LAST) && !w_eoi_ok) begin
                    w_wdog = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win    <= '0;
            r_valid  <= 1'b0;
            r_svc    <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_spur   <= 1'b0;
            r_mism   <= 1'b0;
            r_tmo    <= 1'b0;
            int_out  <= 1'b0;
            o_eoi    <= 1'b0;
            o_eoi_id <= '0;
        end else begin
            // Winner is frozen in service; on leaving, drop the stale valid so
            // the old winner cannot re-raise the IRQ before fresh arbitration.
            if (r_state != S_SERVICE) begin
                r_win   <= w_arb_idx;
                r_valid <= w_arb_any;
            end else if (w_next == S_IDLE) begin
                r_valid <= 1'b0;
            end

            if (w_ack) r_svc <= r_win;

            if (w_ack)                                           r_cnt <= '0;
            else if (r_state == S_SERVICE && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);

            if (w_ctrl_wr) r_en <= i_data[0];

            // Sticky set wins over a same-cycle write-one-to-clear.
            r_spur <= w_spur    | (r_spur & ~(w_stat_wr & i_data[2]));
            r_mism <= w_eoi_bad | (r_mism & ~(w_stat_wr & i_data[3]));
            r_tmo  <= w_wdog    | (r_tmo  & ~(w_stat_wr & i_data[4]));

            int_out <= (w_next == S_PEND);
            o_eoi   <= w_eoi_ok | w_wdog;
            if (w_eoi_ok || w_wdog) o_eoi_id <= r_svc;
        end
    end

endmodule
